mem_access_unit: RTL and testbench

Parametrised memory access unit; the next-generation replacement for the separate MAR, MDR, load sign-extension and MFA/MFC glue in the datapath. It accepts one load/store request at a time from the control unit, validates size and alignment, and drives the MFA/MFC handshake to RAM. It returns a right-justified, sign- or zero-extended load result, or a completion pulse for a store. Widths are generic, 64-bit transfers are added, and misaligned or stalled accesses are reported explicitly.

---
 rtl/mem_access_unit.sv | 99 +++++++++
 tb/tb_mem_access_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: one-at-a-time load/store unit driving the MFA/MFC RAM handshake.
// Define MAU_TIMEOUT_EN to abort accesses whose MFC does not arrive within TIMEOUT_CYC cycles.
module mem_access_unit #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              i_clk,
  input  logic              i_clr_n,
  input  logic              i_req,
  input  logic              i_rw,
  input  logic [1:0]        i_size,
  input  logic              i_sgn,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_fault,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_mem_mfa,
  output logic              o_mem_rw,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [1:0]        o_mem_size,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_mfc
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t r_state, w_next;
  logic              r_sgn, r_fault, w_fault, w_tmo, w_sbit;
  logic [DATA_W-1:0] w_mask_w, w_mask_r, w_ext;

  function automatic logic [DATA_W-1:0] f_mask(input logic [1:0] sz);
    return sz == 2'd0 ? DATA_W'(8'hFF) :
           sz == 2'd1 ? DATA_W'(16'hFFFF) :
           sz == 2'd2 ? DATA_W'(32'hFFFF_FFFF) : {DATA_W{1'b1}};
  endfunction

  assign w_mask_w = f_mask(i_size);
  assign w_mask_r = f_mask(o_mem_size);
  assign w_fault  = (i_size == 2'd3 && DATA_W == 32) |
                    (i_size == 2'd1 && i_addr[0]) |
                    (i_size == 2'd2 && |i_addr[1:0]) |
                    (i_size == 2'd3 && |i_addr[2:0]);
  assign w_sbit   = r_sgn & (o_mem_size == 2'd0 ? i_mem_rdata[7] :
                             o_mem_size == 2'd1 ? i_mem_rdata[15] :
                             o_mem_size == 2'd2 ? i_mem_rdata[31] : i_mem_rdata[DATA_W-1]);
  // Bits outside the transfer are replaced by the sign (or zero) fill.
  assign w_ext    = (i_mem_rdata & w_mask_r) | ({DATA_W{w_sbit}} & ~w_mask_r);

`ifdef MAU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] r_cnt;
  assign w_tmo = (r_cnt == CW'(TIMEOUT_CYC - 1)) & ~i_mem_mfc;
  always_ff @(posedge i_clk or negedge i_clr_n)
    if (!i_clr_n) r_cnt <= '0;
    else if (r_state != WAIT) r_cnt <= '0;
    else if (!i_mem_mfc) r_cnt <= r_cnt + 1'b1;
`else
  assign w_tmo = 1'b0 && (TIMEOUT_CYC > 0);
`endif

  always_comb begin
    w_next    = r_state;
    o_busy    = r_state != IDLE;
    o_done    = r_state == RESP;
    o_mem_mfa = r_state == WAIT;
    o_fault   = (r_state == RESP) & r_fault;
    unique case (r_state)
      IDLE:    w_next = i_req ? (w_fault ? RESP : WAIT) : IDLE;
      WAIT:    w_next = (i_mem_mfc | w_tmo) ? RESP : WAIT;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_clr_n)
    if (!i_clr_n) begin
      r_state     <= IDLE;
      r_sgn       <= 1'b0;
      r_fault     <= 1'b0;
      o_rdata     <= '0;
      o_mem_rw    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_size  <= '0;
      o_mem_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && i_req) begin
        o_mem_rw    <= i_rw;
        o_mem_size  <= i_size;
        r_sgn       <= i_sgn;
        o_mem_addr  <= i_addr;
        o_mem_wdata <= i_wdata & w_mask_w;
        r_fault     <= w_fault;
      end
      if (r_state == WAIT && w_tmo) r_fault <= 1'b1;
      if (r_state == WAIT && i_mem_mfc && o_mem_rw) o_rdata <= w_ext;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of a 32-bit and a 64-bit mem_access_unit.
module tb_mem_access_unit;
  logic clk = 0, clr_n = 0;
  logic req = 0, rw = 0, sgn = 0, mfc = 0;
  logic [1:0] size = 0;
  logic [7:0] addr = 0;
  logic [31:0] wdata = 0, mem_rdata = 0;
  logic busy, done, fault, mfa, mem_rw;
  logic [1:0] mem_size;
  logic [7:0] mem_addr;
  logic [31:0] rdata, mem_wdata;
  logic req64 = 0, rw64 = 0, sgn64 = 0, mfc64 = 0;
  logic [1:0] size64 = 0;
  logic [7:0] addr64 = 0;
  logic [63:0] wdata64 = 0, mem_rdata64 = 0;
  logic busy64, done64, fault64, mfa64, mem_rw64;
  logic [1:0] mem_size64;
  logic [7:0] mem_addr64;
  logic [63:0] rdata64, mem_wdata64;
  int checks = 0, errors = 0, n;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(32), .ADDR_W(8), .TIMEOUT_CYC(4)) u32 (
    .i_clk(clk), .i_clr_n(clr_n), .i_req(req), .i_rw(rw), .i_size(size), .i_sgn(sgn),
    .i_addr(addr), .i_wdata(wdata), .o_busy(busy), .o_done(done), .o_fault(fault),
    .o_rdata(rdata), .o_mem_mfa(mfa), .o_mem_rw(mem_rw), .o_mem_addr(mem_addr),
    .o_mem_size(mem_size), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_mfc(mfc));

  mem_access_unit #(.DATA_W(64), .ADDR_W(8), .TIMEOUT_CYC(4)) u64 (
    .i_clk(clk), .i_clr_n(clr_n), .i_req(req64), .i_rw(rw64), .i_size(size64), .i_sgn(sgn64),
    .i_addr(addr64), .i_wdata(wdata64), .o_busy(busy64), .o_done(done64), .o_fault(fault64),
    .o_rdata(rdata64), .o_mem_mfa(mfa64), .o_mem_rw(mem_rw64), .o_mem_addr(mem_addr64),
    .o_mem_size(mem_size64), .o_mem_wdata(mem_wdata64), .i_mem_rdata(mem_rdata64), .i_mem_mfc(mfc64));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go32(input logic r, input logic [1:0] s, input logic g, input logic [7:0] a, input logic [31:0] w);
    rw = r; size = s; sgn = g; addr = a; wdata = w; req = 1;
    tick();
    req = 0;
  endtask

  task automatic go64(input logic r, input logic [1:0] s, input logic g, input logic [7:0] a, input logic [63:0] w);
    rw64 = r; size64 = s; sgn64 = g; addr64 = a; wdata64 = w; req64 = 1;
    tick();
    req64 = 0;
  endtask

  initial begin
    #2;
    chk("rst_ctl", {busy, done, fault, mfa, mem_rw, mem_size}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mar", {mem_addr, mem_wdata}, 0);
    #1 clr_n = 1;
    // zero-wait byte loads, signed then unsigned
    mem_rdata = 32'h0000_00F3; mfc = 1;
    go32(1, 2'd0, 1, 8'h11, 0);
    chk("b_wait", {busy, mfa, done}, 3'b110);
    chk("b_mar", mem_addr, 8'h11);
    tick();
    chk("b_done", {done, fault, mfa}, 3'b100);
    chk("b_sx", rdata, 32'hFFFF_FFF3);
    tick();
    chk("b_idle", {busy, done}, 0);
    go32(1, 2'd0, 0, 8'h11, 0);
    tick();
    chk("b_zx", {done, rdata}, {1'b1, 32'h0000_00F3});
    tick();
    // halfword store with 3 wait cycles
    mfc = 0;
    go32(0, 2'd1, 0, 8'h20, 32'hDEAD_BEEF);
    chk("h_wdata", mem_wdata, 32'h0000_BEEF);
    chk("h_mem", {mem_rw, mem_size}, 3'b001);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      n += int'(mfa);
      if (i == 3) mfc = 1;
      tick();
    end
    chk("h_mfa_cnt", n, 4);
    chk("h_done", {done, fault, mfa}, 3'b100);
    chk("h_rdata", rdata, 32'h0000_00F3);
    mfc = 0;
    tick();
    // size/alignment faults
    go32(1, 2'd2, 1, 8'h06, 0);
    chk("mis_w", {busy, done, fault, mfa}, 4'b1110);
    tick();
    chk("mis_w_idle", {busy, done, fault, mfa}, 0);
    go32(1, 2'd3, 0, 8'h00, 0);
    chk("dw32", {done, fault, mfa}, 3'b110);
    chk("dw32_rd", rdata, 32'h0000_00F3);
    tick();
    // sign extension of halfword and word loads
    mem_rdata = 32'h1234_8001; mfc = 1;
    go32(1, 2'd1, 1, 8'h02, 0);
    tick();
    chk("h_sx", {done, fault, rdata}, {2'b10, 32'hFFFF_8001});
    tick();
    mem_rdata = 32'h8000_0000;
    go32(1, 2'd2, 1, 8'h04, 0);
    tick();
    chk("w32", rdata, 32'h8000_0000);
    tick();
    // request held high is re-accepted after RESP
    mem_rdata = 32'h0000_0055;
    rw = 1; size = 0; sgn = 0; addr = 8'h01; req = 1;
    tick();
    tick();
    chk("held_done", done, 1);
    tick();
    chk("held_idle", busy, 0);
    tick();
    chk("held_acc", {busy, mfa}, 2'b11);
    req = 0;
    tick();
    tick();
    mfc = 0;
`ifdef MAU_TIMEOUT_EN
    mem_rdata = 32'h0000_00A5;
    go32(1, 2'd2, 0, 8'h10, 0);
    n = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      n += int'(mfa);
      tick();
    end
    chk("tmo_n", n, 4);
    chk("tmo_df", {done, fault}, 2'b11);
    chk("tmo_rd", rdata, 32'h0000_0055);
    tick();
    go32(1, 2'd0, 0, 8'h10, 0);
    repeat (3) tick();
    mfc = 1;
    tick();
    chk("tmo_win", {done, fault, rdata}, {2'b10, 32'h0000_00A5});
    mfc = 0;
    tick();
`else
    go32(1, 2'd2, 0, 8'h10, 0);
    repeat (20) tick();
    chk("no_tmo", {busy, mfa, done}, 3'b110);
    mfc = 1;
    tick();
    chk("no_tmo_done", {done, fault}, 2'b10);
    mfc = 0;
    tick();
`endif
    // 64-bit instance
    mfc64 = 1; mem_rdata64 = 64'h8000_0000_0000_0001;
    go64(1, 2'd3, 1, 8'h08, 0);
    tick();
    chk("dw64", {done64, fault64}, 2'b10);
    chk("dw64_rd", rdata64, 64'h8000_0000_0000_0001);
    tick();
    mem_rdata64 = 64'h0000_0000_8000_0000;
    go64(1, 2'd2, 1, 8'h0C, 0);
    tick();
    chk("w64_sx", rdata64, 64'hFFFF_FFFF_8000_0000);
    tick();
    go64(1, 2'd3, 0, 8'h0C, 0);
    chk("dw64_mis", {done64, fault64, mfa64}, 3'b110);
    tick();
    go64(0, 2'd2, 0, 8'h10, 64'h1122_3344_5566_7788);
    chk("w64_wdata", mem_wdata64, 64'h0000_0000_5566_7788);
    tick();
    tick();
    mfc64 = 0;
    // reset during WAIT
    go32(0, 2'd0, 0, 8'h05, 32'h0000_00AB);
    chk("clr_pre", mfa, 1);
    #2 clr_n = 0;
    #1;
    chk("clr", {busy, mfa, done}, 0);
    chk("clr_rd", rdata, 0);
    #2 clr_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("clr_nodone", {done, busy}, 0);
    end
    mem_rdata = 32'h0000_007F;
    go32(1, 2'd0, 1, 8'h40, 0);
    req = 1;
    tick();
    req = 0; mfc = 1;
    tick();
    chk("post_rst", {done, fault, rdata}, {2'b10, 32'h0000_007F});
    mfc = 0;
    tick();
    chk("post_idle", busy, 0);
    tick();
    chk("pulse_ign", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
